// File: rtl/fetch_override_sequencer_if.sv
// Bundle between the decode-side override sequencer and the IF/ID fetch buffer.
// master = sequencer side, slave = fetch buffer / pipeline side.
interface fetch_override_sequencer_if #(
   parameter int OPW = 5
);
   logic [OPW-1:0] inst_opcode;
   logic           inst_valid;
   logic           flush;
   logic           stall;
   logic           cs_call;
   logic           cs_ret;
   logic           cs_rti;
   logic           previous_rti;
   logic           fetch_NOP;
   logic           cs_ldm;
   logic           pc_hold;
   logic           busy;

   modport master (
      input  inst_opcode, inst_valid, flush, stall,
      output cs_call, cs_ret, cs_rti, previous_rti, fetch_NOP, cs_ldm, pc_hold, busy
   );

   modport slave (
      output inst_opcode, inst_valid, flush, stall,
      input  cs_call, cs_ret, cs_rti, previous_rti, fetch_NOP, cs_ldm, pc_hold, busy
   );
endinterface

// File: rtl/fetch_override_sequencer.sv
// Expands CALL/RET/RTI/LDM into multi-cycle fetch-buffer override sequences and
// inserts NOP bubbles on flush. Outputs are Moore-decoded from registered state.
module fetch_override_sequencer #(
   parameter int unsigned    OPW           = 5,
   parameter logic [OPW-1:0] OP_CALL       = 5'b11000,
   parameter logic [OPW-1:0] OP_RET        = 5'b11001,
   parameter logic [OPW-1:0] OP_RTI        = 5'b11010,
   parameter logic [OPW-1:0] OP_LDM        = 5'b10010,
   parameter int unsigned    CALL_BUBBLES  = 2,
   parameter int unsigned    RET_BUBBLES   = 3,
   parameter int unsigned    FLUSH_BUBBLES = 2,
   parameter int unsigned    CW            = 3
) (
   input logic                       clk,
   input logic                       reset,
   fetch_override_sequencer_if.master bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CALL_PUSH = 3'd1;
   localparam logic [2:0] RET_POP   = 3'd2;
   localparam logic [2:0] RTI_POP   = 3'd3;
   localparam logic [2:0] RTI_FLAGS = 3'd4;
   localparam logic [2:0] LDM_IMM   = 3'd5;
   localparam logic [2:0] BUBBLE    = 3'd6;

   localparam logic [CW-1:0] CALL_CNT  = CW'(CALL_BUBBLES);
   localparam logic [CW-1:0] RET_CNT   = CW'(RET_BUBBLES);
   localparam logic [CW-1:0] FLUSH_CNT = CW'(FLUSH_BUBBLES);

   logic [2:0]    state, state_next;
   logic [CW-1:0] cnt, cnt_next;

   // A zero-length bubble request collapses straight to IDLE.
   function automatic logic [2:0] bubble_or_idle(input logic [CW-1:0] n);
      return (n == '0) ? IDLE : BUBBLE;
   endfunction

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (!bus.stall) begin
         case (state)
            IDLE: begin
               if (bus.flush) begin
                  state_next = bubble_or_idle(FLUSH_CNT);
                  cnt_next   = FLUSH_CNT;
               end else if (bus.inst_valid) begin
                  if (bus.inst_opcode == OP_CALL)      state_next = CALL_PUSH;
                  else if (bus.inst_opcode == OP_RET)  state_next = RET_POP;
                  else if (bus.inst_opcode == OP_RTI)  state_next = RTI_POP;
                  else if (bus.inst_opcode == OP_LDM)  state_next = LDM_IMM;
               end
            end
            // Stack sequences never see flush; they always run to completion.
            CALL_PUSH: begin
               state_next = bubble_or_idle(CALL_CNT);
               cnt_next   = CALL_CNT;
            end
            RET_POP: begin
               state_next = bubble_or_idle(RET_CNT);
               cnt_next   = RET_CNT;
            end
            RTI_POP: state_next = RTI_FLAGS;
            RTI_FLAGS: begin
               state_next = bubble_or_idle(RET_CNT);
               cnt_next   = RET_CNT;
            end
            LDM_IMM: begin
               if (bus.flush) begin
                  state_next = bubble_or_idle(FLUSH_CNT);
                  cnt_next   = FLUSH_CNT;
               end else begin
                  state_next = IDLE;
               end
            end
            BUBBLE: begin
               if (bus.flush) begin
                  state_next = bubble_or_idle(FLUSH_CNT);
                  cnt_next   = FLUSH_CNT;
               end else if (cnt == CW'(1)) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next   = cnt - CW'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   assign bus.cs_call      = (state == CALL_PUSH);
   assign bus.pc_hold      = (state == CALL_PUSH);
   assign bus.cs_ret       = (state == RET_POP);
   assign bus.cs_rti       = (state == RTI_POP);
   assign bus.previous_rti = (state == RTI_FLAGS);
   assign bus.cs_ldm       = (state == LDM_IMM);
   assign bus.fetch_NOP    = (state == LDM_IMM) || (state == BUBBLE);
   assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_fetch_override_sequencer.sv
// Scoreboard bench: a slot-list reference model queues the expected output word
// per clock; a negedge monitor pops and compares against the DUT.
module tb_fetch_override_sequencer;

   localparam logic [4:0] OP_CALL = 5'b11000;
   localparam logic [4:0] OP_RET  = 5'b11001;
   localparam logic [4:0] OP_RTI  = 5'b11010;
   localparam logic [4:0] OP_LDM  = 5'b10010;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam int CALL_B = 2, RET_B = 3, FLUSH_B = 2;

   // word = {cs_call, cs_ret, cs_rti, previous_rti, fetch_NOP, cs_ldm, pc_hold, busy}
   localparam logic [7:0] W_IDLE  = 8'b0000_0000;
   localparam logic [7:0] W_CALL  = 8'b1000_0011;
   localparam logic [7:0] W_RET   = 8'b0100_0001;
   localparam logic [7:0] W_RTI   = 8'b0010_0001;
   localparam logic [7:0] W_FLAGS = 8'b0001_0001;
   localparam logic [7:0] W_LDM   = 8'b0000_1101;
   localparam logic [7:0] W_NOP   = 8'b0000_1001;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_override_sequencer_if #(.OPW(5)) bus ();
   fetch_override_sequencer_if #(.OPW(5)) bus2 ();

   fetch_override_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
   fetch_override_sequencer #(.RET_BUBBLES(0)) dut_r0 (.clk(clk), .reset(reset), .bus(bus2));

   assign bus2.inst_opcode = bus.inst_opcode;
   assign bus2.inst_valid  = bus.inst_valid;
   assign bus2.flush       = bus.flush;
   assign bus2.stall       = bus.stall;

   logic [7:0] obs, obs2;
   assign obs  = {bus.cs_call, bus.cs_ret, bus.cs_rti, bus.previous_rti,
                  bus.fetch_NOP, bus.cs_ldm, bus.pc_hold, bus.busy};
   assign obs2 = {bus2.cs_call, bus2.cs_ret, bus2.cs_rti, bus2.previous_rti,
                  bus2.fetch_NOP, bus2.cs_ldm, bus2.pc_hold, bus2.busy};

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] cur = W_IDLE;
   logic [7:0] pend[$];
   logic [7:0] sb[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_nops(input int n);
      for (int i = 0; i < n; i++) pend.push_back(W_NOP);
   endtask

   // Each accepted command expands to a fixed list of output slots; flush in an
   // interruptible slot replaces whatever slots remain.
   task automatic model_edge(input logic [4:0] opc, input logic v, input logic f, input logic s);
      if (s) return;
      if (cur == W_IDLE) begin
         pend.delete();
         if (f) add_nops(FLUSH_B);
         else if (v) begin
            if (opc == OP_CALL)     begin pend.push_back(W_CALL); add_nops(CALL_B); end
            else if (opc == OP_RET) begin pend.push_back(W_RET); add_nops(RET_B); end
            else if (opc == OP_RTI) begin pend.push_back(W_RTI); pend.push_back(W_FLAGS); add_nops(RET_B); end
            else if (opc == OP_LDM) pend.push_back(W_LDM);
         end
      end else if ((cur == W_LDM || cur == W_NOP) && f) begin
         pend.delete();
         add_nops(FLUSH_B);
      end
      cur = (pend.size() > 0) ? pend.pop_front() : W_IDLE;
   endtask

   task automatic step(input logic [4:0] opc, input logic v, input logic f, input logic s);
      bus.inst_opcode = opc;
      bus.inst_valid  = v;
      bus.flush       = f;
      bus.stall       = s;
      @(posedge clk);
      #1;
      model_edge(opc, v, f, s);
      sb.push_back(cur);
   endtask

   task automatic reset_step();
      reset = 1'b0;
      @(posedge clk);
      #1;
      cur = W_IDLE;
      pend.delete();
      sb.push_back(W_IDLE);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) chk("sb_word", obs, sb.pop_front());
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] opc;
      logic [31:0] r;
      bus.inst_opcode = OP_CALL;
      bus.inst_valid  = 1'b1;
      bus.flush       = 1'b0;
      bus.stall       = 1'b0;
      #2 reset = 1'b0;
      repeat (3) reset_step();
      reset = 1'b1;

      step(OP_CALL, 1, 0, 0);
      repeat (4) step(OP_ADD, 0, 0, 0);

      step(OP_RTI, 1, 0, 0);
      repeat (6) step(OP_ADD, 1, 0, 0);

      step(OP_LDM, 1, 0, 0);
      step(OP_ADD, 1, 1, 0);
      repeat (3) step(OP_ADD, 1, 0, 0);

      // RET with flush in RET_POP; the RET_BUBBLES=0 instance must skip bubbles.
      step(OP_RET, 1, 0, 0);
      chk("r0_ret_pop", obs2, W_RET);
      step(OP_ADD, 1, 1, 0);
      chk("r0_ret_to_idle", obs2, W_IDLE);
      repeat (4) step(OP_ADD, 1, 0, 0);

      step(OP_CALL, 1, 0, 0);
      step(OP_ADD, 1, 0, 0);
      repeat (4) step(OP_CALL, 1, 0, 1);
      repeat (3) step(OP_ADD, 1, 0, 0);

      step(OP_RTI, 1, 0, 0);
      step(OP_ADD, 1, 0, 0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("async_reset_drop", obs, W_IDLE);
      cur = W_IDLE;
      pend.delete();
      repeat (2) reset_step();
      reset = 1'b1;
      repeat (3) step(OP_ADD, 1, 0, 0);

      for (int i = 0; i < 800; i++) begin
         r = $urandom();
         case ($urandom_range(0, 5))
            0: opc = OP_CALL;
            1: opc = OP_RET;
            2: opc = OP_RTI;
            3: opc = OP_LDM;
            4: opc = OP_ADD;
            default: opc = r[4:0];
         endcase
         step(opc, ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 15),
              ($urandom_range(0, 99) < 15));
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
